// File: rtl/alien_swarm_if.sv
// Bus between alien_swarm and its neighbours: collision requests from the
// laser logic, and formation state towards the renderer.
interface alien_swarm_if #(
    parameter int N  = 32,
    parameter int CW = $clog2(N + 1)
) ();
    logic          tick;
    logic          laserValid;
    logic [9:0]    xLaser;
    logic [9:0]    yLaser;
    logic          laserDone;
    logic          laserHit;
    logic          busy;
    logic [9:0]    xAlien;
    logic [9:0]    yAlien;
    logic [N-1:0]  alive;
    logic [CW-1:0] aliveCount;
    logic          victory;
    logic          defeat;

    modport master (
        output tick, laserValid, xLaser, yLaser,
        input  laserDone, laserHit, busy, xAlien, yAlien, alive, aliveCount,
               victory, defeat
    );

    modport slave (
        input  tick, laserValid, xLaser, yLaser,
        output laserDone, laserHit, busy, xAlien, yAlien, alive, aliveCount,
               victory, defeat
    );
endinterface

// File: rtl/alien_swarm.sv
// Alien formation engine: autonomous bounce/drop march paced by tick, with a
// one-alien-per-cycle laser collision scan behind a valid/done handshake.
module alien_swarm #(
    parameter int NB_LIN       = 4,
    parameter int NB_COL       = 8,
    parameter int ALIEN_W      = 20,
    parameter int ALIEN_H      = 10,
    parameter int GAP_H        = 20,
    parameter int GAP_V        = 10,
    parameter int X0           = 40,
    parameter int Y0           = 40,
    parameter int STEP_X       = 4,
    parameter int STEP_Y       = 15,
    parameter int LEFT_LIMIT   = 5,
    parameter int RIGHT_LIMIT  = 635,
    parameter int BOTTOM_LIMIT = 440,
    parameter int PERIOD_MIN   = 2,
    parameter int SPEED_SHIFT  = 0
) (
    input logic        clk,
    input logic        reset,
    alien_swarm_if.slave bus
);
    localparam int N  = NB_LIN * NB_COL;
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(PERIOD_MIN + N + 1);
    localparam int RB = (NB_LIN > 1) ? $clog2(NB_LIN) : 1;
    localparam int CB = (NB_COL > 1) ? $clog2(NB_COL) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PH = ALIEN_W + GAP_H;
    localparam int PV = ALIEN_H + GAP_V;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_MOVE, S_CHECK, S_OVER} state_t;

    state_t          r_state, n_state;
    logic [9:0]      r_x, n_x, r_y, n_y, r_xl, n_xl, r_yl, n_yl;
    logic            r_dir, n_dir;
    logic [N-1:0]    r_alive, n_alive;
    logic [CW-1:0]   r_cnt, n_cnt;
    logic [SW-1:0]   r_step, n_step;
    logic            r_done, n_done, r_hit, n_hit;
    logic            r_vic, n_vic, r_def, n_def, r_pend, n_pend;
    logic [RB-1:0]   r_row, n_row;
    logic [CB-1:0]   r_col, n_col;

    logic [NB_COL-1:0] w_colany;
    logic [NB_LIN-1:0] w_rowany;
    logic [CB-1:0]     w_lc, w_rc;
    logic [RB-1:0]     w_bc;
    logic [IW-1:0]     w_idx;
    logic [10:0]       w_ax, w_ay, w_xl, w_yl;
    logic [10:0]       w_redge, w_ledge, w_low;
    logic              w_hit, w_last;
    logic [SW-1:0]     w_reload;

    // Formation extents from the live alive map
    always_comb begin
        w_colany = '0;
        w_rowany = '0;
        for (int unsigned r = 0; r < NB_LIN; r++) begin
            for (int unsigned c = 0; c < NB_COL; c++) begin
                if (r_alive[IW'(r * NB_COL + c)]) begin
                    w_colany[CB'(c)] = 1'b1;
                    w_rowany[RB'(r)] = 1'b1;
                end
            end
        end
        w_lc = '0;
        w_rc = '0;
        w_bc = '0;
        for (int unsigned c = 0; c < NB_COL; c++)
            if (w_colany[CB'(c)]) w_rc = CB'(c);
        for (int unsigned i = 0; i < NB_COL; i++)
            if (w_colany[CB'(NB_COL - 1 - i)]) w_lc = CB'(NB_COL - 1 - i);
        for (int unsigned r = 0; r < NB_LIN; r++)
            if (w_rowany[RB'(r)]) w_bc = RB'(r);
    end

    assign w_idx    = IW'(r_row) * IW'(NB_COL) + IW'(r_col);
    assign w_ax     = {1'b0, r_x} + 11'(r_col) * 11'(PH);
    assign w_ay     = {1'b0, r_y} + 11'(r_row) * 11'(PV);
    assign w_xl     = {1'b0, r_xl};
    assign w_yl     = {1'b0, r_yl};
    assign w_hit    = r_alive[w_idx] && (w_xl >= w_ax) && (w_xl < w_ax + 11'(ALIEN_W))
                      && (w_yl >= w_ay) && (w_yl < w_ay + 11'(ALIEN_H));
    assign w_last   = (r_row == '0) && (r_col == CB'(NB_COL - 1));
    assign w_redge  = {1'b0, r_x} + 11'(w_rc) * 11'(PH) + 11'(ALIEN_W + STEP_X);
    assign w_ledge  = {1'b0, r_x} + 11'(w_lc) * 11'(PH);
    assign w_low    = {1'b0, r_y} + 11'(w_bc) * 11'(PV) + 11'(ALIEN_H);
    assign w_reload = SW'(PERIOD_MIN) + SW'(r_cnt >> SPEED_SHIFT);

    always_comb begin
        n_state = r_state;
        n_x     = r_x;
        n_y     = r_y;
        n_dir   = r_dir;
        n_alive = r_alive;
        n_cnt   = r_cnt;
        n_step  = r_step;
        n_done  = 1'b0;
        n_hit   = 1'b0;
        n_vic   = r_vic;
        n_def   = r_def;
        n_pend  = r_pend;
        n_xl    = r_xl;
        n_yl    = r_yl;
        n_row   = r_row;
        n_col   = r_col;
        if (bus.tick && (r_state != S_IDLE) && (r_state != S_OVER)) n_pend = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.laserValid) begin
                    // a tick losing to a laser request is kept, not dropped
                    if (bus.tick) n_pend = 1'b1;
                    n_xl    = bus.xLaser;
                    n_yl    = bus.yLaser;
                    n_row   = RB'(NB_LIN - 1);
                    n_col   = '0;
                    n_state = S_SCAN;
                end else if (bus.tick || r_pend) begin
                    n_pend = 1'b0;
                    if (r_step <= SW'(1)) begin
                        n_step  = '0;
                        n_state = S_MOVE;
                    end else begin
                        n_step = r_step - 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (w_hit) begin
                    n_alive[w_idx] = 1'b0;
                    n_cnt          = r_cnt - 1'b1;
                    n_done         = 1'b1;
                    n_hit          = 1'b1;
                    if (r_cnt == CW'(1)) begin
                        n_vic   = 1'b1;
                        n_state = S_OVER;
                    end else begin
                        n_state = S_IDLE;
                    end
                end else if (w_last) begin
                    n_done  = 1'b1;
                    n_state = S_IDLE;
                end else if (r_col == CB'(NB_COL - 1)) begin
                    n_col = '0;
                    n_row = r_row - 1'b1;
                end else begin
                    n_col = r_col + 1'b1;
                end
            end
            S_MOVE: begin
                n_step  = w_reload;
                n_state = S_CHECK;
                if (r_dir) begin
                    if (w_redge > 11'(RIGHT_LIMIT)) begin
                        n_y   = r_y + 10'(STEP_Y);
                        n_dir = 1'b0;
                    end else begin
                        n_x = r_x + 10'(STEP_X);
                    end
                end else begin
                    if (w_ledge < 11'(LEFT_LIMIT + STEP_X)) begin
                        n_y   = r_y + 10'(STEP_Y);
                        n_dir = 1'b1;
                    end else begin
                        n_x = r_x - 10'(STEP_X);
                    end
                end
            end
            S_CHECK: begin
                if (w_low > 11'(BOTTOM_LIMIT)) begin
                    n_def   = 1'b1;
                    n_state = S_OVER;
                end else begin
                    n_state = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_x     <= 10'(X0);
            r_y     <= 10'(Y0);
            r_dir   <= 1'b1;
            r_alive <= '1;
            r_cnt   <= CW'(N);
            r_step  <= SW'(PERIOD_MIN + (N >> SPEED_SHIFT));
            r_done  <= 1'b0;
            r_hit   <= 1'b0;
            r_vic   <= 1'b0;
            r_def   <= 1'b0;
            r_pend  <= 1'b0;
            r_xl    <= '0;
            r_yl    <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= n_state;
            r_x     <= n_x;
            r_y     <= n_y;
            r_dir   <= n_dir;
            r_alive <= n_alive;
            r_cnt   <= n_cnt;
            r_step  <= n_step;
            r_done  <= n_done;
            r_hit   <= n_hit;
            r_vic   <= n_vic;
            r_def   <= n_def;
            r_pend  <= n_pend;
            r_xl    <= n_xl;
            r_yl    <= n_yl;
            r_row   <= n_row;
            r_col   <= n_col;
        end
    end

    assign bus.laserDone  = r_done;
    assign bus.laserHit   = r_hit;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.xAlien     = r_x;
    assign bus.yAlien     = r_y;
    assign bus.alive      = r_alive;
    assign bus.aliveCount = r_cnt;
    assign bus.victory    = r_vic;
    assign bus.defeat     = r_def;
endmodule
